// File: rtl/fread_loader_if.sv
// Groups the read-request handshake, the returned byte stream and the memory write port.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready on requests; the byte stream and memory port have no backpressure.
interface fread_loader_if #(
    parameter int ADDR_W = 17
);
    logic [31:0]       req_file_id;
    logic [31:0]       req_offset;
    logic [10:0]       req_len;
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        resp_data;
    logic              resp_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;

    // Loader side: issues requests, consumes bytes, writes memory.
    modport master (
        output req_file_id, req_offset, req_len, req_valid,
        input  req_ready,
        input  resp_data, resp_valid,
        output mem_addr, mem_wdata, mem_we
    );

    // Engine/memory side.
    modport slave (
        input  req_file_id, req_offset, req_len, req_valid,
        output req_ready,
        output resp_data, resp_valid,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/fread_loader.sv
// Loads N_CHUNKS chunks of CHUNK_LEN bytes from a file-read engine into a linear memory.
// Latency: each accepted byte is written to memory one cycle after its resp_valid.
// Backpressure: requests held until req_ready; byte stream cannot be stalled, a long gap times out to ERR.
module fread_loader #(
    parameter int          ADDR_W      = 17,
    parameter int          CHUNK_LEN   = 2048,
    parameter int          N_CHUNKS    = 32,
    parameter logic [31:0] BASE_OFFSET = 32'h0,
    parameter int          TIMEOUT_W   = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          file_id,
    fread_loader_if.master       bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [7:0]           chunk_idx
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RECV,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [11:0]          LAST_BYTE  = 12'(CHUNK_LEN - 1);
    localparam logic [7:0]           LAST_CHUNK = 8'(N_CHUNKS - 1);
    localparam logic [31:0]          CHUNK_STEP = 32'(CHUNK_LEN);
    // One below all-ones: the counter reaches all-ones on the same edge the FSM enters ERR.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST   = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t                state_q, state_nxt;
    logic [11:0]           byte_cnt;
    logic [ADDR_W-1:0]     total_cnt;
    logic [TIMEOUT_W-1:0]  tmo_cnt;
    logic [31:0]           req_offset_q;
    logic [7:0]            chunk_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [7:0]            mem_wdata_q;
    logic                  mem_we_q;
    logic                  start_acc;
    logic                  byte_acc;
    logic                  chunk_end;

    // Next-state and per-cycle strobes; abort beats start only while a load is running.
    always_comb begin
        state_nxt = state_q;
        start_acc = 1'b0;
        byte_acc  = 1'b0;
        chunk_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = ST_REQ;
                end else if (abort) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_REQ: begin
                if (abort) begin
                    state_nxt = ST_ERR;
                end else if (bus.req_ready) begin
                    state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (abort) begin
                    state_nxt = ST_ERR;
                end else if (bus.resp_valid) begin
                    byte_acc = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        chunk_end = 1'b1;
                        state_nxt = (chunk_q == LAST_CHUNK) ? ST_DONE : ST_REQ;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = ST_ERR;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset drops to IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Counters, request offset and the registered memory write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt     <= '0;
            total_cnt    <= '0;
            tmo_cnt      <= '0;
            req_offset_q <= '0;
            chunk_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            mem_we_q <= byte_acc;
            if (start_acc) begin
                byte_cnt     <= '0;
                total_cnt    <= '0;
                chunk_q      <= '0;
                req_offset_q <= BASE_OFFSET;
            end
            if (byte_acc) begin
                mem_addr_q  <= total_cnt;
                mem_wdata_q <= bus.resp_data;
                total_cnt   <= total_cnt + ADDR_W'(1);
                byte_cnt    <= chunk_end ? 12'd0 : byte_cnt + 12'd1;
            end
            if (chunk_end && (chunk_q != LAST_CHUNK)) begin
                chunk_q      <= chunk_q + 8'd1;
                req_offset_q <= req_offset_q + CHUNK_STEP;
            end
            // Idle timer only runs in RECV, so it is zero on every entry.
            if (state_q == ST_RECV && !byte_acc) begin
                tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    assign bus.req_file_id = file_id;
    assign bus.req_offset  = req_offset_q;
    assign bus.req_len     = 11'(CHUNK_LEN - 1);
    assign bus.req_valid   = (state_q == ST_REQ);
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_we      = mem_we_q;

    assign busy      = (state_q == ST_REQ) || (state_q == ST_RECV);
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERR);
    assign chunk_idx = chunk_q;

endmodule

// File: doc/fread_loader.md
FREAD_LOADER -- requirements
Module: fread_loader

Interface
REQ-001 Parameter ADDR_W, default 17: width of the memory write address.
REQ-002 Parameter CHUNK_LEN, default 2048: bytes per read request; legal range 1..2048.
REQ-003 Parameter N_CHUNKS, default 32: number of chunks per load; at least 1.
REQ-004 Parameter BASE_OFFSET, default 32'h0: file offset of chunk 0.
REQ-005 Parameter TIMEOUT_W, default 24: width of the inter-byte timeout counter.
REQ-006 Port clk, in, 1: single clock; all logic on its rising edge.
REQ-007 Port rst_n, in, 1: reset, asynchronous, active-low.
REQ-008 Port start, in, 1: single-cycle pulse that begins a load.
REQ-009 Port abort, in, 1: single-cycle pulse that cancels a load.
REQ-010 Port file_id, in, 32: file identifier; passed through to req_file_id.
REQ-011 Ports req_file_id out 32, req_offset out 32, req_len out 11, req_valid out 1, req_ready in 1: read-request handshake to the file-read engine.
REQ-012 Ports resp_data in 8, resp_valid in 1: byte stream returned for the request.
REQ-013 Ports mem_addr out ADDR_W, mem_wdata out 8, mem_we out 1: memory write port.
REQ-014 Ports busy out 1, done out 1, error out 1, chunk_idx out 8: status outputs.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ, RECV, DONE and ERR.
REQ-016 In IDLE, DONE or ERR, start SHALL do all of the following at once: clear the chunk and byte counters, clear done and error, and enter REQ on the next cycle.
REQ-017 In REQ, req_valid SHALL be 1, with req_offset = BASE_OFFSET + chunk_idx*CHUNK_LEN (32-bit, wraps) and req_len = CHUNK_LEN-1.
REQ-018 req_valid, req_offset and req_len SHALL be held stable until a cycle in which req_valid and req_ready are both 1; the FSM then enters RECV and req_valid drops the next cycle.
REQ-019 In RECV, each resp_valid cycle SHALL produce, one cycle later, mem_we=1, mem_wdata=resp_data and mem_addr=total byte count (modulo 2^ADDR_W); the byte count then increments.
REQ-020 resp_valid SHALL be ignored outside RECV, including in REQ before the handshake completes.
REQ-021 When the in-chunk byte count reaches CHUNK_LEN: if chunk_idx = N_CHUNKS-1, enter DONE; otherwise increment chunk_idx and enter REQ.
REQ-022 In RECV, the timeout counter SHALL clear on entry and on each resp_valid; if it reaches all-ones, enter ERR.
REQ-023 abort SHALL force ERR from any state except IDLE; a pending mem_we from the previous cycle still completes.
REQ-024 start while in REQ or RECV SHALL be ignored.
REQ-025 If start and abort occur in the same cycle, abort SHALL win in REQ/RECV, and start SHALL win in IDLE/DONE/ERR.
REQ-026 busy SHALL be 1 exactly in REQ and RECV; done SHALL be 1 exactly in DONE; error SHALL be 1 exactly in ERR.
REQ-027 chunk_idx SHALL hold the index of the current or last chunk (8 bits, wraps); N_CHUNKS is limited to 256.
REQ-028 Bytes beyond 2^ADDR_W SHALL wrap the address silently; the integrator must ensure CHUNK_LEN*N_CHUNKS <= 2^ADDR_W.

Reset
REQ-029 On rst_n=0 the FSM SHALL enter IDLE immediately, independent of clk.
REQ-030 Reset values: req_valid, mem_we, busy, done, error = 0; chunk_idx, req_offset, mem_addr, mem_wdata, counters = 0; req_len = CHUNK_LEN-1.
REQ-031 Reset mid-load SHALL discard all progress, and no further mem_we SHALL occur until a new start.

Verification
REQ-032 Normal load, CHUNK_LEN=4, N_CHUNKS=2, BASE_OFFSET=32'h1000: start, req_ready after 3 cycles, 8 bytes 0x10..0x17 -> req_offset 0x1000 then 0x1004; mem writes at addr 0..7 with data 0x10..0x17; done=1; busy=0.
REQ-033 Handshake stall: hold req_ready=0 for 10 cycles with stray resp_valid pulses -> req_valid and req_offset stable; no mem_we.
REQ-034 Timeout, TIMEOUT_W=4: after 2 of 4 bytes, stop resp_valid -> ERR (error=1) within 16 cycles; mem_addr last written = 1.
REQ-035 Abort during RECV of chunk 1 -> error=1 and busy=0; a following start restarts at req_offset 0x1000, chunk_idx 0.
REQ-036 Async reset asserted mid-byte-stream between clock edges -> all outputs at reset values before the next clk edge; later resp_valid produces no mem_we.
REQ-037 Address wrap, ADDR_W=2, CHUNK_LEN=4, N_CHUNKS=2 -> second chunk writes addr 0..3 again; done=1.
